// File: rtl/detector_scheduler_if.sv
// Request/grant bundle for the four serial channels feeding detector_scheduler.
interface detector_scheduler_if;
  logic [3:0] req_valid;
  logic [3:0] req_bit;
  logic [3:0] req_ready;

  modport master (output req_valid, output req_bit, input req_ready);
  modport slave  (input req_valid, input req_bit, output req_ready);
endinterface

// File: rtl/detector_scheduler.sv
// One Mealy "1010" detector time-shared by four channels through a rotating one-hot grant.
// Define OVERLAP_EN to restart at S2 after a detection (overlapping matches); default restarts at S0.
module detector_scheduler #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  detector_scheduler_if.slave  bus,
  input  logic                 cnt_clr,
  output logic                 det,
  output logic [1:0]           det_ch,
  output logic [CNT_W-1:0]     det_cnt
);
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_e;

`ifdef OVERLAP_EN
  localparam state_e RESTART = S2;
`else
  localparam state_e RESTART = S0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            st_q [4];
  state_e            st_d [4];
  logic [1:0]        ptr_q, ptr_d;
  logic              det_q, det_d;
  logic [1:0]        det_ch_q, det_ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [1:0]        idx_s;
  logic [1:0]        gidx_s;
  logic              found_s;
  logic              xfer_s;
  state_e            cur_s, nxt_s;
  logic              bit_s, hit_s;

  // Rotating search from ptr_q; the lowest offset with valid wins, so scan offsets high to low.
  always_comb begin
    idx_s   = 2'd0;
    gidx_s  = 2'd0;
    found_s = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      idx_s   = ptr_q + 2'(k);
      found_s = found_s | bus.req_valid[idx_s];
      gidx_s  = bus.req_valid[idx_s] ? idx_s : gidx_s;
    end
    xfer_s        = found_s & rst;
    bus.req_ready = xfer_s ? (4'b0001 << gidx_s) : 4'b0000;
  end

  // Shared detector: next state of the granted channel and the counter/pulse updates.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      st_d[i] = st_q[i];
    end
    cur_s = st_q[gidx_s];
    bit_s = bus.req_bit[gidx_s];
    hit_s = 1'b0;
    nxt_s = cur_s;
    case (cur_s)
      S0:      nxt_s = bit_s ? S1 : S0;
      S1:      nxt_s = bit_s ? S1 : S2;
      S2:      nxt_s = bit_s ? S3 : S0;
      S3: begin
        hit_s = ~bit_s;
        nxt_s = bit_s ? S1 : RESTART;
      end
      default: nxt_s = S0;
    endcase
    st_d[gidx_s] = xfer_s ? nxt_s : cur_s;
    ptr_d        = xfer_s ? (gidx_s + 2'd1) : ptr_q;
    det_d        = xfer_s & hit_s;
    det_ch_d     = det_d ? gidx_s : 2'd0;
    if (cnt_clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (det_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        st_q[i] <= S0;
      end
      ptr_q    <= 2'd0;
      det_q    <= 1'b0;
      det_ch_q <= 2'd0;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < 4; i++) begin
        st_q[i] <= st_d[i];
      end
      ptr_q    <= ptr_d;
      det_q    <= det_d;
      det_ch_q <= det_ch_d;
      cnt_q    <= cnt_d;
    end
  end

  assign det     = det_q;
  assign det_ch  = det_ch_q;
  assign det_cnt = cnt_q;

endmodule

// File: tb/tb_detector_scheduler.sv
// Scoreboard bench for detector_scheduler: a reference model predicts grant, det pulse and counts.
module tb_detector_scheduler;
  logic       clk;
  logic       rst;
  logic       cnt_clr;
  logic       det8, det2;
  logic [1:0] det_ch8, det_ch2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  detector_scheduler_if bus8 ();
  detector_scheduler_if bus2 ();

  detector_scheduler u_dut8 (
    .clk(clk), .rst(rst), .bus(bus8), .cnt_clr(cnt_clr),
    .det(det8), .det_ch(det_ch8), .det_cnt(cnt8)
  );

  detector_scheduler #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .cnt_clr(cnt_clr),
    .det(det2), .det_ch(det_ch2), .det_cnt(cnt2)
  );

  typedef struct {
    logic       det;
    logic [1:0] ch;
  } exp_t;

`ifdef OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  exp_t sb[$];
  bit   chq [4][$];
  int   det_cyc[$];
  int   m_st [4];
  int   m_ptr, m_cnt8, m_cnt2;
  int   n_chk, n_bad, pulses, cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] b, input logic clr);
    bus8.req_valid = v; bus2.req_valid = v;
    bus8.req_bit   = b; bus2.req_bit   = b;
    cnt_clr        = clr;
  endtask

  task automatic push_bits(input int ch, input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) chq[ch].push_back(bits[i]);
  endtask

  function automatic int pending();
    return chq[0].size() + chq[1].size() + chq[2].size() + chq[3].size();
  endfunction

  // Entered at posedge+1; leaves at the following posedge+1.
  task automatic step(input bit clr_on_det);
    logic [3:0] v, b, g;
    int   gi, idx;
    logic bt, clr;
    exp_t e;
    v = 4'b0000; b = 4'b0000; gi = -1;
    for (int i = 0; i < 4; i++) begin
      v[i] = (chq[i].size() != 0);
      b[i] = v[i] ? chq[i][0] : 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      idx = (m_ptr + k) % 4;
      if (gi < 0 && v[idx]) gi = idx;
    end
    g = 4'b0000;
    e.det = 1'b0; e.ch = 2'd0;
    if (gi >= 0) begin
      g[gi] = 1'b1;
      bt = b[gi];
      case (m_st[gi])
        0: m_st[gi] = bt ? 1 : 0;
        1: m_st[gi] = bt ? 1 : 2;
        2: m_st[gi] = bt ? 3 : 0;
        default: begin
          if (bt) m_st[gi] = 1;
          else begin
            e.det = 1'b1; e.ch = 2'(gi);
            m_st[gi] = OVL ? 2 : 0;
          end
        end
      endcase
      m_ptr = (gi + 1) % 4;
      void'(chq[gi].pop_front());
    end
    clr = clr_on_det && e.det;
    if (clr) begin
      m_cnt8 = 0; m_cnt2 = 0;
    end else if (e.det) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    sb.push_back(e);
    drive(v, b, clr);
    #1;
    check_eq("ready8", bus8.req_ready, g);
    check_eq("ready2", bus2.req_ready, g);
    @(posedge clk); #1;
    e = sb.pop_front();
    check_eq("det", det8, e.det);
    check_eq("det_ch", det_ch8, e.ch);
    check_eq("det_w2", det2, e.det);
    check_eq("cnt8", cnt8, m_cnt8);
    check_eq("cnt2", cnt2, m_cnt2);
    if (det8) begin
      pulses++;
      det_cyc.push_back(cyc + 1);
    end
    cyc++;
    drive(4'b0000, 4'b0000, 1'b0);
  endtask

  task automatic drain(input bit clr_on_det);
    int n;
    n = 0;
    while (pending() != 0 && n < 100) begin
      step(clr_on_det);
      n++;
    end
    check_eq("drain", pending(), 0);
  endtask

  task automatic do_reset();
    drive(4'b1111, 4'b0000, 1'b0);
    #2; rst = 1'b0; #1;
    check_eq("rst_ready8", bus8.req_ready, 0);
    check_eq("rst_ready2", bus2.req_ready, 0);
    check_eq("rst_det", det8, 0);
    check_eq("rst_det_ch", det_ch8, 0);
    check_eq("rst_cnt8", cnt8, 0);
    check_eq("rst_cnt2", cnt2, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      m_st[i] = 0;
      chq[i].delete();
    end
    m_ptr = 0; m_cnt8 = 0; m_cnt2 = 0;
    sb.delete(); det_cyc.delete();
    pulses = 0; cyc = 0;
  endtask

  initial begin
    n_chk = 0; n_bad = 0;
    rst = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0);
    do_reset();

    // Single channel 1010.
    push_bits(0, 8'b1010, 4);
    drain(1'b0);
    check_eq("t028_pulses", pulses, 1);
    check_eq("t028_cycle", det_cyc.size() > 0 ? det_cyc[0] : -1, 4);
    check_eq("t028_cnt", cnt8, 1);

    // Overlap behaviour on channel 2.
    do_reset();
    push_bits(2, 8'b101010, 6);
    drain(1'b0);
    check_eq("t029_pulses", pulses, OVL ? 2 : 1);
    check_eq("t029_cnt", cnt8, OVL ? 2 : 1);

    // All four channels contending.
    do_reset();
    for (int c = 0; c < 4; c++) push_bits(c, 8'b1010, 4);
    drain(1'b0);
    check_eq("t030_pulses", det_cyc.size(), 4);
    for (int i = 0; i < det_cyc.size(); i++) check_eq("t030_cycle", det_cyc[i], 13 + i);
    check_eq("t030_cnt", cnt8, 4);

    // Interleaved channels keep independent state.
    do_reset();
    push_bits(0, 8'b10, 2); drain(1'b0);
    push_bits(1, 8'b10, 2); drain(1'b0);
    push_bits(0, 8'b10, 2); drain(1'b0);
    check_eq("t031_pulses", pulses, 1);
    push_bits(1, 8'b10, 2); drain(1'b0);
    check_eq("t031_ch1_s2", pulses, 2);

    // Saturation of a 2-bit counter, then clear colliding with a detection.
    do_reset();
    for (int r = 0; r < 5; r++) push_bits(0, 8'b1010, 4);
    drain(1'b0);
    check_eq("t032_pulses", pulses, OVL ? 9 : 5);
    check_eq("t032_sat", cnt2, 3);
    do_reset();
    push_bits(0, 8'b1010, 4); drain(1'b0);
    check_eq("t032_pre", cnt8, 1);
    push_bits(0, 8'b1010, 4); drain(1'b1);
    check_eq("t032_clr_pulses", pulses, OVL ? 3 : 2);
    check_eq("t032_clr_cnt8", cnt8, 0);
    check_eq("t032_clr_cnt2", cnt2, 0);

    // Reset mid-pattern discards partial state.
    do_reset();
    push_bits(1, 8'b101, 3); drain(1'b0);
    do_reset();
    push_bits(1, 8'b0, 1); drain(1'b0);
    check_eq("t033_pulses", pulses, 0);
    check_eq("t033_cnt", cnt8, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
